hs_bus_sync: RTL and testbench

HS_BUS_SYNC -- requirements
Module: hs_bus_sync

---
 rtl/hs_bus_sync_pkg.sv | 13 +
 rtl/hs_bus_sync_bit.sv | 21 ++
 rtl/hs_bus_sync.sv | 125 ++++++++++++
 tb/tb_hs_bus_sync.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_bus_sync_pkg.sv
// hs_bus_sync_pkg: shared types and limits for the
// 4-phase REQ/ACK bus synchronizer.
package hs_bus_sync_pkg;

  localparam int NUM_STAGES_MIN = 2;
  localparam int NUM_STAGES_MAX = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACK_HI = 1'b1
  } state_t;

endpackage

// File: rtl/hs_bus_sync_bit.sv
// hs_bit_sync: NUM_STAGES flop single-bit synchronizer,
// async active-low reset to 0.
module hs_bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_d,
  output logic o_q
);

  logic [NUM_STAGES-1:0] r_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_sync <= '0;
    else      r_sync <= {r_sync[NUM_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[NUM_STAGES-1];

endmodule

// File: rtl/hs_bus_sync.sv
// hs_bus_sync: 4-phase REQ/ACK bus capture into CLK domain.
// Optional parity check enabled by HS_BUS_SYNC_PARITY_EN.
module hs_bus_sync
  import hs_bus_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic                 REQ,
  input  logic                 DST_READY,
  output logic                 ACK,
  output logic [BUS_WIDTH-1:0] SYNC_BUS,
  output logic                 ENABLE_PULSE
`ifdef HS_BUS_SYNC_PARITY_EN
  ,
  input  logic                 UNSYNC_PAR,
  output logic                 PAR_ERR
`endif
);

  if (NUM_STAGES < NUM_STAGES_MIN ||
      NUM_STAGES > NUM_STAGES_MAX) begin : g_bad_stages
    $error("hs_bus_sync: NUM_STAGES must be 2..4");
  end

  logic                 w_req_s;
  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_ack;
  logic                 w_ack_nx;
  logic                 r_pulse;
  logic                 w_pulse_nx;
  logic [BUS_WIDTH-1:0] r_bus;
  logic [BUS_WIDTH-1:0] w_bus_nx;
`ifdef HS_BUS_SYNC_PARITY_EN
  logic                 r_par_err;
  logic                 w_par_err_nx;
  logic                 w_par_ok;
`endif

  hs_bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_req_sync (
    .CLK(CLK),
    .RST(RST),
    .i_d(REQ),
    .o_q(w_req_s)
  );

`ifdef HS_BUS_SYNC_PARITY_EN
  assign w_par_ok = ((^UNSYNC_BUS) == UNSYNC_PAR);
`endif

  always_comb begin
    w_state_nx = r_state;
    w_ack_nx   = r_ack;
    w_pulse_nx = 1'b0;
    w_bus_nx   = r_bus;
`ifdef HS_BUS_SYNC_PARITY_EN
    w_par_err_nx = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        w_ack_nx = 1'b0;
        if (w_req_s && DST_READY) begin
          w_state_nx = ACK_HI;
          w_ack_nx   = 1'b1;
`ifdef HS_BUS_SYNC_PARITY_EN
          // bad word is dropped but the handshake still completes
          if (w_par_ok) begin
            w_bus_nx   = UNSYNC_BUS;
            w_pulse_nx = 1'b1;
          end else begin
            w_par_err_nx = 1'b1;
          end
`else
          w_bus_nx   = UNSYNC_BUS;
          w_pulse_nx = 1'b1;
`endif
        end
      end
      ACK_HI: begin
        if (!w_req_s) begin
          w_state_nx = IDLE;
          w_ack_nx   = 1'b0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_ack_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_pulse <= 1'b0;
      r_bus   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ack   <= w_ack_nx;
      r_pulse <= w_pulse_nx;
      r_bus   <= w_bus_nx;
    end
  end

`ifdef HS_BUS_SYNC_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_par_err <= 1'b0;
    else      r_par_err <= w_par_err_nx;
  end

  assign PAR_ERR = r_par_err;
`endif

  assign ACK          = r_ack;
  assign SYNC_BUS     = r_bus;
  assign ENABLE_PULSE = r_pulse;

endmodule

// File: tb/tb_hs_bus_sync.sv
// tb_hs_bus_sync: scoreboard bench for hs_bus_sync.
// Expected words queued at stimulus; monitor pops on ENABLE_PULSE.
module tb_hs_bus_sync;

  logic       CLK;
  logic       RST;
  logic [7:0] UNSYNC_BUS;
  logic       REQ;
  logic       DST_READY;
  logic       ACK;
  logic [7:0] SYNC_BUS;
  logic       ENABLE_PULSE;
`ifdef HS_BUS_SYNC_PARITY_EN
  logic       UNSYNC_PAR;
  logic       PAR_ERR;
`endif

  int n_chk;
  int n_fail;
  logic [7:0] exp_q[$];
  logic prev_pulse;

  hs_bus_sync #(
    .NUM_STAGES(2),
    .BUS_WIDTH (8)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .UNSYNC_BUS  (UNSYNC_BUS),
    .REQ         (REQ),
    .DST_READY   (DST_READY),
    .ACK         (ACK),
    .SYNC_BUS    (SYNC_BUS),
    .ENABLE_PULSE(ENABLE_PULSE)
`ifdef HS_BUS_SYNC_PARITY_EN
    ,
    .UNSYNC_PAR  (UNSYNC_PAR),
    .PAR_ERR     (PAR_ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_s();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input logic [7:0] w);
    UNSYNC_BUS = w;
`ifdef HS_BUS_SYNC_PARITY_EN
    UNSYNC_PAR = ^w;
`endif
  endtask

  task automatic wait_ack(input logic v, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      edge_s();
      if (ACK === v) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RST === 1'b1 && ENABLE_PULSE === 1'b1) begin
      chk("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none",
                 SYNC_BUS);
      end else begin
        chk("sb_word", {24'd0, SYNC_BUS}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_pulse = (RST === 1'b1) && (ENABLE_PULSE === 1'b1);
  end

  initial begin
    int npulse;
    prev_pulse = 1'b0;
    n_chk  = 0;
    n_fail = 0;
    RST       = 1'b0;
    REQ       = 1'b0;
    DST_READY = 1'b1;
    set_word(8'h00);
    #1;
    chk("rst_ack",   {31'd0, ACK}, 32'd0);
    chk("rst_pulse", {31'd0, ENABLE_PULSE}, 32'd0);
    chk("rst_bus",   {24'd0, SYNC_BUS}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // first word, latency NUM_STAGES+1
    set_word(8'hA5);
    REQ = 1'b1;
    exp_q.push_back(8'hA5);
    edge_s();
    edge_s();
    chk("lat_ack_e2", {31'd0, ACK}, 32'd0);
    chk("lat_pulse_e2", {31'd0, ENABLE_PULSE}, 32'd0);
    edge_s();
    chk("lat_ack_e3", {31'd0, ACK}, 32'd1);
    chk("lat_pulse_e3", {31'd0, ENABLE_PULSE}, 32'd1);
    chk("lat_bus_e3", {24'd0, SYNC_BUS}, 32'h0A5);
    edge_s();
    chk("lat_pulse_e4", {31'd0, ENABLE_PULSE}, 32'd0);
    chk("lat_ack_e4", {31'd0, ACK}, 32'd1);

    // ACK fall latency
    @(negedge CLK);
    REQ = 1'b0;
    edge_s();
    edge_s();
    chk("fall_ack_e2", {31'd0, ACK}, 32'd1);
    edge_s();
    chk("fall_ack_e3", {31'd0, ACK}, 32'd0);

    // second word
    @(negedge CLK);
    set_word(8'h3C);
    REQ = 1'b1;
    exp_q.push_back(8'h3C);
    wait_ack(1'b1, "w2_ack_rise");
    chk("w2_bus", {24'd0, SYNC_BUS}, 32'h03C);
    @(negedge CLK);
    REQ = 1'b0;
    wait_ack(1'b0, "w2_ack_fall");

    // stall with DST_READY low
    @(negedge CLK);
    DST_READY = 1'b0;
    set_word(8'h5A);
    REQ = 1'b1;
    exp_q.push_back(8'h5A);
    repeat (10) begin
      edge_s();
      chk("stall_ack", {31'd0, ACK}, 32'd0);
      chk("stall_pulse", {31'd0, ENABLE_PULSE}, 32'd0);
      chk("stall_bus", {24'd0, SYNC_BUS}, 32'h03C);
    end
    @(negedge CLK);
    DST_READY = 1'b1;
    edge_s();
    chk("unstall_pulse", {31'd0, ENABLE_PULSE}, 32'd1);
    chk("unstall_ack", {31'd0, ACK}, 32'd1);
    chk("unstall_bus", {24'd0, SYNC_BUS}, 32'h05A);
    @(negedge CLK);
    REQ = 1'b0;
    wait_ack(1'b0, "stall_ack_fall");

    // reset mid-handshake
    @(negedge CLK);
    set_word(8'hC3);
    REQ = 1'b1;
    exp_q.push_back(8'hC3);
    wait_ack(1'b1, "rh_ack_rise");
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rh_ack", {31'd0, ACK}, 32'd0);
    chk("rh_pulse", {31'd0, ENABLE_PULSE}, 32'd0);
    chk("rh_bus", {24'd0, SYNC_BUS}, 32'd0);
    repeat (2) @(negedge CLK);
    exp_q.push_back(8'hC3);
    RST = 1'b1;
    edge_s();
    edge_s();
    chk("rr_ack_e2", {31'd0, ACK}, 32'd0);
    edge_s();
    chk("rr_ack_e3", {31'd0, ACK}, 32'd1);
    chk("rr_pulse_e3", {31'd0, ENABLE_PULSE}, 32'd1);
    chk("rr_bus_e3", {24'd0, SYNC_BUS}, 32'h0C3);
    @(negedge CLK);
    REQ = 1'b0;
    wait_ack(1'b0, "rr_ack_fall");

    // long REQ high: one capture only
    @(negedge CLK);
    set_word(8'h99);
    REQ = 1'b1;
    exp_q.push_back(8'h99);
    npulse = 0;
    repeat (50) begin
      edge_s();
      if (ENABLE_PULSE === 1'b1) npulse++;
    end
    chk("long_pulses", npulse, 32'd1);
    @(negedge CLK);
    REQ = 1'b0;
    wait_ack(1'b0, "long_ack_fall");

`ifdef HS_BUS_SYNC_PARITY_EN
    @(negedge CLK);
    UNSYNC_BUS = 8'h01;
    UNSYNC_PAR = 1'b0;
    REQ = 1'b1;
    wait_ack(1'b1, "par_ack_rise");
    chk("par_err_hi", {31'd0, PAR_ERR}, 32'd1);
    chk("par_pulse", {31'd0, ENABLE_PULSE}, 32'd0);
    chk("par_bus", {24'd0, SYNC_BUS}, 32'h099);
    edge_s();
    chk("par_err_lo", {31'd0, PAR_ERR}, 32'd0);
    chk("par_ack_hold", {31'd0, ACK}, 32'd1);
    @(negedge CLK);
    REQ = 1'b0;
    wait_ack(1'b0, "par_ack_fall");
`endif

    repeat (3) edge_s();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
